// File: rtl/dpram_arb_pkg.sv
// Shared types and defaults for the dual-port RAM arbiter.
// Read-return tags are sized for the largest supported client count.
package dpram_arb_pkg;
  localparam int DW_DEF      = 8;
  localparam int AW_DEF      = 6;
  localparam int MAX_CLIENTS = 8;

  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CW = cw_of(MAX_CLIENTS);

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] id;
  } rd_tag_t;
endpackage

// File: rtl/dpram_arbiter_if.sv
// Client-side request/grant/return bundle for dpram_arbiter.
// Clients hold req/wr/addr/wdata until their cl_gnt bit is seen.
import dpram_arb_pkg::*;

interface dpram_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);
  logic [N-1:0]    cl_req;
  logic [N-1:0]    cl_wr;
  logic [N*AW-1:0] cl_addr;
  logic [N*DW-1:0] cl_wdata;
  logic [N-1:0]    cl_gnt;
  logic [N-1:0]    cl_rvalid;
  logic [DW-1:0]   cl_rdata;

  modport master (
    output cl_req, cl_wr, cl_addr, cl_wdata,
    input  cl_gnt, cl_rvalid, cl_rdata
  );

  modport slave (
    input  cl_req, cl_wr, cl_addr, cl_wdata,
    output cl_gnt, cl_rvalid, cl_rdata
  );
endinterface

// File: rtl/dpram_arbiter_rr_arbiter.sv
// Round-robin arbiter, zero-latency combinational grant from a registered pointer.
// Pointer moves past the winner only when the caller asserts advance; otherwise it holds.
import dpram_arb_pkg::*;

module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = cw_of(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);
  logic [IW-1:0] ptr;

  always_comb begin
    int idx;
    idx    = 0;
    any    = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any    = 1'b1;
        gnt_id = IW'(idx);
      end
    end
    gnt = any ? (N'(1) << gnt_id) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance && any) begin
      ptr <= (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
    end
  end
endmodule

// File: rtl/dpram_arbiter.sv
// Shares one dpram between clients: independent RR write/read ports, zero-latency grants.
// Reads return READ_LATENCY cycles after issue; a read colliding with a same-address write is deferred.
import dpram_arb_pkg::*;

module dpram_arbiter #(
  parameter int NUM_CLIENTS  = 4,
  parameter int DW           = DW_DEF,
  parameter int AW           = AW_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  dpram_arbiter_if.slave       cl_bus,
  output logic                 we,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        data_in,
  output logic                 re,
  output logic [AW-1:0]        rd_addr,
  input  logic [DW-1:0]        data_out
);
  localparam int IW = cw_of(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0] wr_cand, rd_cand, wr_gnt, rd_gnt;
  logic [IW-1:0]          wr_id, rd_id;
  logic                   wr_any, rd_any, collision, rd_issue;
  logic [AW-1:0]          wr_addr_sel, rd_addr_sel;
  rd_tag_t                rd_pipe [READ_LATENCY];
  rd_tag_t                rd_tail;

  assign wr_cand = cl_bus.cl_req & cl_bus.cl_wr;
  assign rd_cand = cl_bus.cl_req & ~cl_bus.cl_wr;

  rr_arbiter #(.N(NUM_CLIENTS)) u_wr_arb (
    .clk(clk), .reset(reset), .req(wr_cand), .advance(wr_any),
    .gnt(wr_gnt), .gnt_id(wr_id), .any(wr_any)
  );

  rr_arbiter #(.N(NUM_CLIENTS)) u_rd_arb (
    .clk(clk), .reset(reset), .req(rd_cand), .advance(rd_issue),
    .gnt(rd_gnt), .gnt_id(rd_id), .any(rd_any)
  );

  assign wr_addr_sel = cl_bus.cl_addr[wr_id*AW +: AW];
  assign rd_addr_sel = cl_bus.cl_addr[rd_id*AW +: AW];

  // Holding the read back one cycle guarantees it observes the committed write.
  assign collision = wr_any && rd_any && (wr_addr_sel == rd_addr_sel);
  assign rd_issue  = rd_any && !collision;
  assign rd_tail   = rd_pipe[READ_LATENCY-1];

  always_comb begin
    we               = 1'b0;
    wr_addr          = '0;
    data_in          = '0;
    re               = 1'b0;
    rd_addr          = '0;
    cl_bus.cl_gnt    = '0;
    cl_bus.cl_rvalid = '0;
    cl_bus.cl_rdata  = '0;
    if (reset) begin
      if (wr_any) begin
        we      = 1'b1;
        wr_addr = wr_addr_sel;
        data_in = cl_bus.cl_wdata[wr_id*DW +: DW];
        cl_bus.cl_gnt = wr_gnt;
      end
      if (rd_issue) begin
        re      = 1'b1;
        rd_addr = rd_addr_sel;
        cl_bus.cl_gnt = cl_bus.cl_gnt | rd_gnt;
      end
      if (rd_tail.valid) begin
        cl_bus.cl_rvalid = NUM_CLIENTS'(1) << rd_tail.id;
        cl_bus.cl_rdata  = data_out;
      end
    end
  end

  // Tag pipeline mirrors the RAM read latency so returns stay in issue order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < READ_LATENCY; k++) rd_pipe[k] <= '0;
    end else begin
      rd_pipe[0].valid <= rd_issue;
      rd_pipe[0].id    <= CW'(rd_id);
      for (int k = 1; k < READ_LATENCY; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
  end
endmodule
